// File: rtl/sim_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sim_run_ctrl: core reset sequencer, run clock-enable, cycle budget and    |
// | halt-streak detector. Optional fetch signature: SIM_RUN_CTRL_SIGNATURE_EN |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sim_run_ctrl #(
  parameter int                INST_W      = 32,
  parameter int                CNT_W       = 32,
  parameter int                RST_CYCLES  = 2,
  parameter int                DIV         = 2,
  parameter int                MAX_CYCLES  = 500,
  parameter logic [INST_W-1:0] HALT_INST   = '0,
  parameter int                HALT_REPEAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] IF_Inst,
  input  logic              inst_valid,
  output logic              core_rst,
  output logic              run_en,
  output logic              clk2_en,
  output logic [CNT_W-1:0]  cycle,
  output logic              done,
  output logic              halted,
  output logic              timeout,
  output logic [INST_W-1:0] signature
);

  localparam int HOLD_W = $clog2(RST_CYCLES + 1);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int STRK_W = $clog2(HALT_REPEAT + 1);

  localparam logic [HOLD_W-1:0] C_HOLD_INIT = HOLD_W'(RST_CYCLES);
  localparam logic [DIV_W-1:0]  C_DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [STRK_W-1:0] C_STRK_MAX  = STRK_W'(HALT_REPEAT);
  localparam logic [CNT_W-1:0]  C_CYC_LAST  = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RESET_HOLD = 2'd0,
    S_RUN        = 2'd1,
    S_HALTED     = 2'd2,
    S_TIMEOUT    = 2'd3
  } state_e;

  state_e             state_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   div_d;
  logic [STRK_W-1:0]  strk_q;
  logic [STRK_W-1:0]  strk_d;
  logic [CNT_W-1:0]   cycle_q;
  logic               core_rst_q;
  logic               run_en_q;
  logic               clk2_en_q;
  logic               done_q;
  logic               halted_q;
  logic               timeout_q;
  logic               halt_hit;

  always_comb begin
    strk_d = strk_q;
    if (inst_valid) begin
      if (IF_Inst == HALT_INST) begin
        strk_d = (strk_q == C_STRK_MAX) ? strk_q : strk_q + STRK_W'(1);
      end else begin
        strk_d = '0;
      end
    end
    div_d    = (div_q == C_DIV_LAST) ? '0 : div_q + DIV_W'(1);
    halt_hit = (strk_d == C_STRK_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RESET_HOLD;
      hold_q     <= C_HOLD_INIT;
      div_q      <= '0;
      strk_q     <= '0;
      cycle_q    <= '0;
      core_rst_q <= 1'b1;
      run_en_q   <= 1'b0;
      clk2_en_q  <= 1'b0;
      done_q     <= 1'b0;
      halted_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        S_RESET_HOLD: begin
          if (hold_q == '0) begin
            state_q    <= S_RUN;
            core_rst_q <= 1'b0;
            run_en_q   <= 1'b1;
            cycle_q    <= '0;
            div_q      <= '0;
            strk_q     <= '0;
            clk2_en_q  <= (C_DIV_LAST == '0);
          end else begin
            hold_q <= hold_q - HOLD_W'(1);
          end
        end
        S_RUN: begin
          cycle_q <= cycle_q + CNT_W'(1);
          strk_q  <= strk_d;
          // A halt decided on the last budget cycle takes precedence over timeout.
          if (halt_hit) begin
            state_q   <= S_HALTED;
            run_en_q  <= 1'b0;
            clk2_en_q <= 1'b0;
            done_q    <= 1'b1;
            halted_q  <= 1'b1;
          end else if (cycle_q == C_CYC_LAST) begin
            state_q   <= S_TIMEOUT;
            run_en_q  <= 1'b0;
            clk2_en_q <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            div_q     <= div_d;
            clk2_en_q <= (div_d == C_DIV_LAST);
          end
        end
        S_HALTED, S_TIMEOUT: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= S_RESET_HOLD;
        end
      endcase
    end
  end

`ifdef SIM_RUN_CTRL_SIGNATURE_EN
  logic [INST_W-1:0] sig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= '0;
    end else if (state_q == S_RUN && inst_valid) begin
      sig_q <= {sig_q[INST_W-2:0], sig_q[INST_W-1]} ^ IF_Inst;
    end
  end

  assign signature = sig_q;
`else
  assign signature = '0;
`endif

  assign core_rst = core_rst_q;
  assign run_en   = run_en_q;
  assign clk2_en  = clk2_en_q;
  assign cycle    = cycle_q;
  assign done     = done_q;
  assign halted   = halted_q;
  assign timeout  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_sim_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sim_run_ctrl: scoreboard bench for sim_run_ctrl (default parameters)  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sim_run_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IF_Inst;
  logic        inst_valid;
  logic        core_rst;
  logic        run_en;
  logic        clk2_en;
  logic [31:0] cycle;
  logic        done;
  logic        halted;
  logic        timeout;
  logic [31:0] signature;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        h;
    logic        t;
    logic [31:0] c;
  } done_rec_t;

  done_rec_t   done_sb[$];
  bit          clk2_sb[$];
  logic [31:0] sig_sb[$];

  always #5 clk = ~clk;

  sim_run_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .IF_Inst    (IF_Inst),
    .inst_valid (inst_valid),
    .core_rst   (core_rst),
    .run_en     (run_en),
    .clk2_en    (clk2_en),
    .cycle      (cycle),
    .done       (done),
    .halted     (halted),
    .timeout    (timeout),
    .signature  (signature)
  );

  function automatic done_rec_t mk_rec(input logic h, input logic t, input logic [31:0] c);
    done_rec_t r;
    r.h = h;
    r.t = t;
    r.c = c;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset for two cycles, release, and return how many edges core_rst stayed high.
  task automatic start_run(output int edges);
    rst        = 1'b1;
    inst_valid = 1'b0;
    IF_Inst    = 32'h1;
    step();
    step();
    rst   = 1'b0;
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      edges++;
      if (!core_rst) break;
    end
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (done) seen = 1'b1;
  endtask

  task automatic test_reset();
    int edges;
    rst        = 1'b1;
    inst_valid = 1'b0;
    IF_Inst    = 32'h0;
    step();
    step();
    checks++;
    if (core_rst !== 1'b1) begin
      errors++; $display("FAIL rst_core_rst: got %b want 1", core_rst);
    end
    checks++;
    if ({run_en, clk2_en, done, halted, timeout} !== 5'b0) begin
      errors++; $display("FAIL rst_flags: got %b want 00000", {run_en, clk2_en, done, halted, timeout});
    end
    checks++;
    if (cycle !== 32'd0 || signature !== 32'd0) begin
      errors++; $display("FAIL rst_counts: cycle=%0d sig=%h want 0/0", cycle, signature);
    end
    rst   = 1'b0;
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      edges++;
      if (!core_rst) break;
    end
    checks++;
    if (edges !== 3) begin
      errors++; $display("FAIL rst_hold_len: got %0d edges want 3", edges);
    end
    checks++;
    if (run_en !== 1'b1 || cycle !== 32'd0) begin
      errors++; $display("FAIL run_entry: run_en=%b cycle=%0d want 1/0", run_en, cycle);
    end
    for (int c = 0; c < 10; c++) clk2_sb.push_back((c % 2) == 1);
    for (int c = 0; c < 10; c++) begin
      bit e;
      e = clk2_sb.pop_front();
      checks++;
      if (clk2_en !== e || cycle !== c) begin
        errors++; $display("FAIL clk2_en_c%0d: clk2_en=%b cycle=%0d want %b/%0d", c, clk2_en, cycle, e, c);
      end
      step();
    end
  endtask

  task automatic test_halt();
    int edges;
    bit seen;
    done_rec_t e;
    start_run(edges);
    for (int i = 0; i < 14; i++) begin
      inst_valid = 1'b1;
      IF_Inst    = (i < 10) ? 32'h1 : 32'h0;
      if (i == 13) done_sb.push_back(mk_rec(1'b1, 1'b0, 32'd14));
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL halt_early_%0d: done=%b want 0", i, done);
      end
      step();
    end
    wait_done(4, seen);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL halt_wait: done=%b want 1", done);
    end
    e = done_sb.pop_front();
    checks++;
    if (halted !== e.h || timeout !== e.t || cycle !== e.c) begin
      errors++; $display("FAIL halt_result: h=%b t=%b cycle=%0d want %b/%b/%0d", halted, timeout, cycle, e.h, e.t, e.c);
    end
    checks++;
    if (run_en !== 1'b0 || clk2_en !== 1'b0 || core_rst !== 1'b0) begin
      errors++; $display("FAIL halt_outs: run_en=%b clk2_en=%b core_rst=%b want 0/0/0", run_en, clk2_en, core_rst);
    end
    for (int i = 0; i < 5; i++) begin
      inst_valid = 1'b1;
      IF_Inst    = 32'h7;
      step();
    end
    checks++;
    if (cycle !== 32'd14 || done !== 1'b1 || halted !== 1'b1) begin
      errors++; $display("FAIL halt_frozen: cycle=%0d done=%b halted=%b want 14/1/1", cycle, done, halted);
    end
  endtask

  task automatic test_streak();
    int edges;
    bit seen;
    done_rec_t e;
    logic        vv [11];
    logic [31:0] ii [11];
    vv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    ii = '{32'h0, 32'h0, 32'h0, 32'h5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    start_run(edges);
    for (int i = 0; i < 11; i++) begin
      inst_valid = vv[i];
      IF_Inst    = ii[i];
      if (i == 10) done_sb.push_back(mk_rec(1'b1, 1'b0, 32'd11));
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL streak_early_%0d: done=%b want 0", i, done);
      end
      step();
    end
    inst_valid = 1'b0;
    wait_done(4, seen);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL streak_wait: done=%b want 1", done);
    end
    e = done_sb.pop_front();
    checks++;
    if (halted !== e.h || timeout !== e.t || cycle !== e.c) begin
      errors++; $display("FAIL streak_result: h=%b t=%b cycle=%0d want %b/%b/%0d", halted, timeout, cycle, e.h, e.t, e.c);
    end
  endtask

  task automatic test_timeout(input bit coincident);
    int edges;
    bit seen;
    done_rec_t e;
    start_run(edges);
    for (int i = 0; i < 500; i++) begin
      inst_valid = 1'b1;
      IF_Inst    = (coincident && i >= 496) ? 32'h0 : 32'h1;
      if (i == 499) begin
        done_sb.push_back(mk_rec(coincident, !coincident, 32'd500));
        checks++;
        if (done !== 1'b0 || cycle !== 32'd499) begin
          errors++; $display("FAIL tmo_last_run_%0d: done=%b cycle=%0d want 0/499", coincident, done, cycle);
        end
      end
      step();
    end
    inst_valid = 1'b0;
    wait_done(4, seen);
    checks++;
    if (!seen) begin
      errors++; $display("FAIL tmo_wait_%0d: done=%b want 1", coincident, done);
    end
    e = done_sb.pop_front();
    checks++;
    if (halted !== e.h || timeout !== e.t || cycle !== e.c) begin
      errors++; $display("FAIL tmo_result_%0d: h=%b t=%b cycle=%0d want %b/%b/%0d", coincident, halted, timeout, cycle, e.h, e.t, e.c);
    end
  endtask

  task automatic test_midrun_reset();
    int edges;
    bit seen;
    done_rec_t e;
    start_run(edges);
    for (int i = 0; i < 100; i++) begin
      inst_valid = 1'b1;
      IF_Inst    = 32'h3;
      step();
    end
    checks++;
    if (cycle !== 32'd100 || run_en !== 1'b1) begin
      errors++; $display("FAIL mid_pre: cycle=%0d run_en=%b want 100/1", cycle, run_en);
    end
    rst = 1'b1;
    step();
    checks++;
    if (core_rst !== 1'b1 || run_en !== 1'b0 || clk2_en !== 1'b0 || cycle !== 32'd0) begin
      errors++; $display("FAIL mid_rst: core_rst=%b run_en=%b clk2_en=%b cycle=%0d want 1/0/0/0", core_rst, run_en, clk2_en, cycle);
    end
    rst        = 1'b0;
    inst_valid = 1'b0;
    edges      = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      edges++;
      if (!core_rst) break;
    end
    checks++;
    if (edges !== 3 || cycle !== 32'd0 || run_en !== 1'b1) begin
      errors++; $display("FAIL mid_restart: edges=%0d cycle=%0d run_en=%b want 3/0/1", edges, cycle, run_en);
    end
    for (int i = 0; i < 4; i++) begin
      inst_valid = 1'b1;
      IF_Inst    = 32'h0;
      if (i == 3) done_sb.push_back(mk_rec(1'b1, 1'b0, 32'd4));
      step();
    end
    inst_valid = 1'b0;
    wait_done(4, seen);
    e = done_sb.pop_front();
    checks++;
    if (!seen || halted !== e.h || timeout !== e.t || cycle !== e.c) begin
      errors++; $display("FAIL mid_halt: done=%b h=%b t=%b cycle=%0d want 1/%b/%b/%0d", done, halted, timeout, cycle, e.h, e.t, e.c);
    end
    rst = 1'b1;
    step();
    checks++;
    if (done !== 1'b0 || halted !== 1'b0 || core_rst !== 1'b1 || cycle !== 32'd0) begin
      errors++; $display("FAIL post_done_rst: done=%b halted=%b core_rst=%b cycle=%0d want 0/0/1/0", done, halted, core_rst, cycle);
    end
    rst = 1'b0;
  endtask

  task automatic test_signature();
    int edges;
    logic        vv [5];
    logic [31:0] ii [5];
    logic [31:0] ee [5];
    vv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    ii = '{32'h1, 32'h2, 32'h8000_0000, 32'h0000_FFFF, 32'h1};
`ifdef SIM_RUN_CTRL_SIGNATURE_EN
    ee = '{32'h1, 32'h0, 32'h8000_0000, 32'h8000_0000, 32'h0};
`else
    ee = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
`endif
    start_run(edges);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] x;
      inst_valid = vv[i];
      IF_Inst    = ii[i];
      sig_sb.push_back(ee[i]);
      step();
      x = sig_sb.pop_front();
      checks++;
      if (signature !== x) begin
        errors++; $display("FAIL signature_%0d: got %h want %h", i, signature, x);
      end
    end
    inst_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    inst_valid = 1'b0;
    IF_Inst    = 32'h0;
    test_reset();
    test_halt();
    test_streak();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_midrun_reset();
    test_signature();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sim_run_ctrl.md
# sim_run_ctrl

Parametrised run controller for the ARM pipeline bench and FPGA bring-up. Sequences core reset, generates the divided clock enable that replaces the free-running half-rate clock, counts run cycles, and ends the run on a halt-instruction streak or a cycle-budget timeout. Sits between the top-level clock/reset and the `ARM` core: it drives the core reset and observes `IF_Inst`.

## Interface

Parameters:
- `INST_W`, 32: width of the observed fetch instruction.
- `CNT_W`, 32: cycle counter width.
- `RST_CYCLES`, 2: core-reset hold length after `rst` falls; must be ≥1.
- `DIV`, 2: clock-enable divide ratio; must be ≥1.
- `MAX_CYCLES`, 500: run budget in cycles; must be ≥1 and < 2^CNT_W.
- `HALT_INST`, 32'h0000_0000: instruction encoding treated as halt.
- `HALT_REPEAT`, 4: consecutive valid halt fetches needed to halt; must be ≥1.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `IF_Inst` input INST_W: fetched instruction from the core.
- `inst_valid` input 1: `IF_Inst` is meaningful this cycle.
- `core_rst` output 1: reset to the core.
- `run_en` output 1: high only in RUN.
- `clk2_en` output 1: one-cycle enable pulse every DIV RUN cycles.
- `cycle` output CNT_W: RUN cycles elapsed.
- `done` output 1: run finished (HALTED or TIMEOUT).
- `halted` output 1: finished by halt streak.
- `timeout` output 1: finished by budget exhaustion.
- `signature` output INST_W: fetch signature (see Configuration).

## Operation

- States: RESET_HOLD, RUN, HALTED, TIMEOUT. All outputs registered.
- `rst`=1 (any state, any time, including mid-run or after done): next state RESET_HOLD; hold counter loads RST_CYCLES; `core_rst`=1; `run_en`=`clk2_en`=`done`=`halted`=`timeout`=0; `cycle`=0; halt streak=0; div counter=0; `signature`=0.
- RESET_HOLD: with `rst`=0, hold counter decrements each cycle; at 0 → RUN. `core_rst` stays 1 throughout.
- RUN: `core_rst`=0, `run_en`=1; `cycle` increments by 1 each cycle, starting from 0 in the first RUN cycle.
- Divider: counter 0..DIV-1, cleared on RUN entry; `clk2_en`=1 in the RUN cycle where counter = DIV-1. DIV=1 → `clk2_en`=1 every RUN cycle.
- Halt streak: in RUN, valid && `IF_Inst`==HALT_INST increments; valid && mismatch clears to 0; `inst_valid`=0 holds. Streak saturates at HALT_REPEAT.
- Halt: the cycle the streak reaches HALT_REPEAT → next state HALTED.
- Timeout: in RUN with `cycle`==MAX_CYCLES-1 → next state TIMEOUT (exactly MAX_CYCLES RUN cycles).
- Simultaneous halt and timeout in the same cycle: HALTED wins; `timeout` stays 0.
- HALTED/TIMEOUT: `done`=1 plus `halted` or `timeout`; `run_en`=`clk2_en`=0; `cycle` frozen; `core_rst`=0; `IF_Inst` ignored; exit only via `rst`.

## Timing

- `core_rst` falls RST_CYCLES+1 edges after the first edge sampling `rst`=0 (RESET_HOLD spends RST_CYCLES cycles, then the RUN transition registers).
- First `clk2_en` pulse: DIV-th RUN cycle.
- `done` rises one cycle after the deciding fetch or the `cycle`==MAX_CYCLES-1 cycle; `cycle` then reads its final value (halt: count at deciding cycle + 1; timeout: MAX_CYCLES).
- Counters never wrap: MAX_CYCLES < 2^CNT_W guarantees termination first.

## Configuration

- `SIM_RUN_CTRL_SIGNATURE_EN` defined: `signature` updates in RUN on each valid fetch as rotate-left-by-1 of itself XOR `IF_Inst`; frozen after done; cleared by `rst`.
- Not defined: no signature register; `signature` tied to 0. All other behaviour identical.

## Test plan

- Reset sequence: `rst` high 2 cycles then low, RST_CYCLES=2 → `core_rst` high for exactly 3 edges after `rst` falls, `cycle`=0 in the first RUN cycle, first `clk2_en` on RUN cycle 2, then every 2nd.
- Halt: feed valid 32'h1 for 10 cycles then 32'h0 ×4 (HALT_REPEAT=4) → `halted`=1, `done`=1 the next cycle, `cycle`=14 frozen, `run_en`=0.
- Streak break/hold: 32'h0 ×3, one mismatch, 32'h0 ×3 with `inst_valid`=0 gaps → no halt; a 4th consecutive valid 32'h0 after the gaps → halt.
- Timeout: never fetch halt, MAX_CYCLES=500 → `timeout`=1 after exactly 500 RUN cycles, `cycle`=500; coincident 4th halt fetch on cycle 499 → `halted`=1, `timeout`=0.
- Mid-run reset: assert `rst` at cycle 100 and after done → all outputs return to reset values next edge, full sequence restarts.
- Signature (macro on): valid fetches 32'h1, 32'h2 → `signature`=32'h0000_0000 (rotate(1)^2=2^2=0); macro off → stays 0.
